pipe_skid_stage: RTL and testbench

//  Generic, parametrised pipeline stage register, successor to the fixed-field inter-stage latches.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_skid_stage_sat_counter.sv | 35 +++
 rtl/pipe_skid_stage.sv | 104 ++++++++++
 tb/tb_pipe_skid_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline skid stage.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
// It holds at all-ones rather than wrapping to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // When clear and increment arrive in the same cycle, clear wins.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised valid/ready pipeline register with a two-entry skid buffer,
// flush (bubble insertion) and a saturating back-pressure counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  // Ready is decoded from the state register only, so there is no
  // combinational ready path from downstream back into upstream.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // An accepted input in the flush cycle is deliberately discarded.
      state_d = S_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (out_valid & ~out_ready),
    .clr_i   (clr_stats),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks for pipe_skid_stage with a 3-bit
// stall counter so saturation is reachable in a few cycles.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [1:0]  occupancy;
  logic        clrStats;
  logic [2:0]  stallCycles;

  int vectors     = 0;
  int miscompares = 0;

  pipe_skid_stage #(
    .DATA_W         (32),
    .CLEAR_ON_FLUSH (1'b1),
    .STALL_CNT_W    (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .flush        (flush),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_data      (inData),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .occupancy    (occupancy),
    .clr_stats    (clrStats),
    .stall_cycles (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                               input logic f, input logic c);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
    clrStats = c;
  endtask

  logic [31:0] model[$];
  logic        holding;
  logic        inFire;
  logic        outFire;

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rstN = 1'b1;
    tick();
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_out_data", outData, 0);
    checkOutput("rst_stall", stallCycles, 0);

    // Asynchronous reset while two entries are held
    applyStimulus(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
    tick();
    inData = 32'hDEAD_0002;
    tick();
    checkOutput("midrst_pre_occ", occupancy, 2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_out_valid", outValid, 0);
    checkOutput("midrst_in_ready", inReady, 1);
    checkOutput("midrst_occupancy", occupancy, 0);
    checkOutput("midrst_out_data", outData, 0);
    checkOutput("midrst_stall", stallCycles, 0);
    tick();
    rstN = 1'b1;
    tick();

    // Back-to-back streaming, one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_in_ready", inReady, 1);
      tick();
      checkOutput("stream_out_valid", outValid, 1);
      checkOutput("stream_out_data", outData, 64'(i));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream_drained_valid", outValid, 0);
    checkOutput("stream_drained_occ", occupancy, 0);
    checkOutput("stream_no_stall", stallCycles, 0);

    // Back-pressure fills the skid entry, then drains in order
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_occ1", occupancy, 1);
    checkOutput("bp_data_a", outData, 32'hA);
    inData = 32'hB;
    tick();
    checkOutput("bp_occ2", occupancy, 2);
    checkOutput("bp_in_ready", inReady, 0);
    checkOutput("bp_hold_a", outData, 32'hA);
    checkOutput("bp_stall1", stallCycles, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_in_ready_indep", inReady, 0);
    tick();
    checkOutput("bp_out_b", outData, 32'hB);
    checkOutput("bp_occ_after1", occupancy, 1);
    checkOutput("bp_in_ready_back", inReady, 1);
    tick();
    checkOutput("bp_empty", occupancy, 0);
    checkOutput("bp_stall_held", stallCycles, 1);
    clrStats = 1'b1;
    tick();
    clrStats = 1'b0;
    checkOutput("bp_clr", stallCycles, 0);

    // Flush with two entries held and a blocked input of 0xC
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    tick();
    inData = 32'h22;
    tick();
    checkOutput("fl_occ2", occupancy, 2);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_occ0", occupancy, 0);
    checkOutput("fl_out_valid", outValid, 0);
    checkOutput("fl_out_data", outData, 0);
    checkOutput("fl_stall_kept", stallCycles, 2);
    // Flush with one entry held and an accepted input of 0xC
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fl1_occ1", occupancy, 1);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    checkOutput("fl1_in_ready", inReady, 1);
    tick();
    checkOutput("fl1_occ0", occupancy, 0);
    checkOutput("fl1_out_data", outData, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fl1_c_dropped", outValid, 0);
    checkOutput("fl1_stall", stallCycles, 3);

    // Stall counter saturation and clear priority
    clrStats = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("cnt_start", stallCycles, 0);
    inValid = 1'b0;
    repeat (10) tick();
    checkOutput("cnt_saturated", stallCycles, 7);
    clrStats = 1'b1;
    tick();
    checkOutput("cnt_clr_priority", stallCycles, 0);
    clrStats = 1'b0;
    tick();
    checkOutput("cnt_restart", stallCycles, 1);
    outReady = 1'b1;
    tick();
    checkOutput("cnt_drained", occupancy, 0);

    // Random valid/ready against a queue model
    holding = 1'b0;
    clrStats = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      outReady = ($urandom_range(0, 3) != 0);
      if (!holding) begin
        inValid = 1'($urandom_range(0, 1));
        inData  = $urandom();
      end
      checkOutput("rnd_in_ready", inReady, 64'(model.size() != 2));
      checkOutput("rnd_out_valid", outValid, 64'(model.size() != 0));
      if (model.size() != 0) checkOutput("rnd_out_data", outData, 64'(model[0]));
      inFire  = inValid && (model.size() != 2);
      outFire = outReady && (model.size() != 0);
      holding = inValid && !inFire;
      if (outFire) void'(model.pop_front());
      if (inFire) model.push_back(inData);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("rnd_final_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
